// File: rtl/alu_pkg.sv
// alu_pkg: opcodes, flag bit indices and flag width shared by the ALU pipeline
package alu_pkg;
    localparam logic [5:0] OP_ADD = 6'b100000;
    localparam logic [5:0] OP_SUB = 6'b100010;
    localparam logic [5:0] OP_AND = 6'b100100;
    localparam logic [5:0] OP_OR  = 6'b100101;
    localparam logic [5:0] OP_XOR = 6'b100110;
    localparam logic [5:0] OP_NOR = 6'b100111;
    localparam logic [5:0] OP_SRL = 6'b000010;
    localparam logic [5:0] OP_SRA = 6'b000011;
    localparam logic [5:0] OP_SLL = 6'b000000;
    localparam int FLAG_W = 5;
    localparam int F_Z    = 0;
    localparam int F_C    = 1;
    localparam int F_V    = 2;
    localparam int F_N    = 3;
    localparam int F_ERR  = 4;
endpackage

// File: rtl/alu_pipe_if.sv
// alu_pipe_if: operand/opcode input handshake and result output handshake of alu_pipe
interface alu_pipe_if #(parameter int N_BITS = 8);
    import alu_pkg::*;
    logic                i_valid;
    logic                o_ready;
    logic [N_BITS-1:0]   i_dato_A;
    logic [N_BITS-1:0]   i_dato_B;
    logic [5:0]          i_operacion;
    logic                o_valid;
    logic                i_ready;
    logic [N_BITS-1:0]   o_alu;
    logic [FLAG_W-1:0]   o_flags;
    modport master (
        output i_valid, i_dato_A, i_dato_B, i_operacion, i_ready,
        input  o_ready, o_valid, o_alu, o_flags
    );
    modport slave (
        input  i_valid, i_dato_A, i_dato_B, i_operacion, i_ready,
        output o_ready, o_valid, o_alu, o_flags
    );
endinterface

// File: rtl/alu_core.sv
// alu_core: combinational ALU producing result and {err, N, V, C, Z} flags
module alu_core
    import alu_pkg::*;
#(
    parameter int N_BITS = 8
) (
    input  logic [N_BITS-1:0] a,
    input  logic [N_BITS-1:0] b,
    input  logic [5:0]        op,
    output logic [N_BITS-1:0] res,
    output logic [FLAG_W-1:0] flags
);
    localparam int M = N_BITS - 1;
    logic [N_BITS:0] sum;
    logic [N_BITS:0] diff;
    logic            c;
    logic            v;
    logic            err;
    always_comb begin
        sum  = {1'b0, a} + {1'b0, b};
        diff = {1'b0, a} - {1'b0, b};
        res  = '0;
        c    = 1'b0;
        v    = 1'b0;
        err  = 1'b0;
        case (op)
            OP_ADD: begin
                res = sum[M:0];
                c   = sum[N_BITS];
                v   = (a[M] == b[M]) && (sum[M] != a[M]);
            end
            OP_SUB: begin
                res = diff[M:0];
                c   = !diff[N_BITS];
                v   = (a[M] != b[M]) && (diff[M] != a[M]);
            end
            OP_AND: res = a & b;
            OP_OR:  res = a | b;
            OP_XOR: res = a ^ b;
            OP_NOR: res = ~(a | b);
            // native shifts already zero/sign fill for amounts >= N_BITS
            OP_SRL: res = a >> b;
            OP_SRA: res = $signed(a) >>> b;
            OP_SLL: res = a << b;
            default: err = 1'b1;
        endcase
        flags        = '0;
        flags[F_Z]   = (res == '0);
        flags[F_C]   = c;
        flags[F_V]   = v;
        flags[F_N]   = res[M];
        flags[F_ERR] = err;
    end
endmodule

// File: rtl/alu_pipe.sv
// alu_pipe: valid/ready pipelined ALU with optional operand stage and registered result stage
module alu_pipe
    import alu_pkg::*;
#(
    parameter int N_BITS = 8,
    parameter int REG_IN = 1
) (
    input  logic     i_clk,
    input  logic     i_rst_n,
    alu_pipe_if.slave bus
);
    logic                s1_valid_q, s1_valid_d;
    logic [N_BITS-1:0]   alu_q, alu_d;
    logic [FLAG_W-1:0]   flags_q, flags_d;
    logic                s1_free;
    logic                feed;
    logic [N_BITS-1:0]   c_a, c_b, res;
    logic [5:0]          c_op;
    logic [FLAG_W-1:0]   flg;
    assign s1_free = !s1_valid_q | bus.i_ready;
    generate
        if (REG_IN != 0) begin : g_in
            logic              s0_valid_q, s0_valid_d;
            logic              s0_adv, in_fire;
            logic [N_BITS-1:0] a_q, a_d, b_q, b_d;
            logic [5:0]        op_q, op_d;
            always_comb begin
                s0_adv     = s0_valid_q & s1_free;
                in_fire    = bus.i_valid & (!s0_valid_q | s0_adv);
                s0_valid_d = in_fire | (s0_valid_q & !s0_adv);
                a_d        = in_fire ? bus.i_dato_A : a_q;
                b_d        = in_fire ? bus.i_dato_B : b_q;
                op_d       = in_fire ? bus.i_operacion : op_q;
            end
            always_ff @(posedge i_clk or negedge i_rst_n) begin
                if (!i_rst_n) begin
                    s0_valid_q <= 1'b0;
                    a_q        <= '0;
                    b_q        <= '0;
                    op_q       <= '0;
                end else begin
                    s0_valid_q <= s0_valid_d;
                    a_q        <= a_d;
                    b_q        <= b_d;
                    op_q       <= op_d;
                end
            end
            assign bus.o_ready = !s0_valid_q | s0_adv;
            assign feed        = s0_adv;
            assign c_a         = a_q;
            assign c_b         = b_q;
            assign c_op        = op_q;
        end else begin : g_byp
            assign bus.o_ready = s1_free;
            assign feed        = bus.i_valid & s1_free;
            assign c_a         = bus.i_dato_A;
            assign c_b         = bus.i_dato_B;
            assign c_op        = bus.i_operacion;
        end
    endgenerate
    alu_core #(.N_BITS(N_BITS)) u_core (
        .a     (c_a),
        .b     (c_b),
        .op    (c_op),
        .res   (res),
        .flags (flg)
    );
    always_comb begin
        s1_valid_d = feed | (s1_valid_q & !bus.i_ready);
        alu_d      = feed ? res : alu_q;
        flags_d    = feed ? flg : flags_q;
    end
    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            s1_valid_q <= 1'b0;
            alu_q      <= '0;
            flags_q    <= '0;
        end else begin
            s1_valid_q <= s1_valid_d;
            alu_q      <= alu_d;
            flags_q    <= flags_d;
        end
    end
    assign bus.o_valid = s1_valid_q;
    assign bus.o_alu   = alu_q;
    assign bus.o_flags = flags_q;
endmodule
